// File: rtl/audio_gain_fifo.sv
// audio_gain_fifo: a small sample FIFO feeding a registered gain stage.
// Gain is chosen by SW at the moment a sample moves from the FIFO into the
// output register. Optional feature macro AUDIO_GAIN_SAT_EN: when defined,
// overflowing shifts clamp to the signed range and pulse clip; when not
// defined, shifted results wrap to DATA_W bits and clip is tied low.
module audio_gain_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int LVL_W  = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic [1:0]        SW,
   output logic [LVL_W-1:0]  level,
   output logic              clip
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wrPtr_q;
   logic [PTR_W-1:0]  rdPtr_q;
   logic [LVL_W-1:0]  level_q;
   logic [LVL_W-1:0]  level_d;
   logic [DATA_W-1:0] outData_q;
   logic              outValid_q;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] headData;
   logic [DATA_W-1:0] loadData;

   // Full is judged from the registered level only, so a pop on the same
   // edge never lets a push into a full FIFO.
   assign in_ready  = (level_q != LVL_W'(DEPTH));
   assign push      = in_valid && in_ready;
   assign pop       = (level_q != '0) && (!outValid_q || out_ready);
   assign headData  = mem_q[rdPtr_q];
   assign out_data  = outData_q;
   assign out_valid = outValid_q;
   assign level     = level_q;

`ifdef AUDIO_GAIN_SAT_EN
   localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

   logic [DATA_W+1:0] ext;
   logic [DATA_W+1:0] wide;
   logic              loadClip;
   logic              clip_q;

   // Shift in a two-bit wider domain, then clamp anything that no longer
   // fits the signed DATA_W range (top three bits must agree).
   always_comb begin
      ext      = {{2{headData[DATA_W-1]}}, headData};
      wide     = '0;
      loadData = '0;
      loadClip = 1'b0;
      case (SW)
         2'b01:   wide = ext << 2;
         2'b11:   wide = ext << 1;
         2'b10:   wide = ext;
         default: wide = '0;
      endcase
      if ((wide[DATA_W+1:DATA_W-1] == 3'b000) || (wide[DATA_W+1:DATA_W-1] == 3'b111)) begin
         loadData = wide[DATA_W-1:0];
      end else if (wide[DATA_W+1]) begin
         loadData = MIN_VAL;
         loadClip = 1'b1;
      end else begin
         loadData = MAX_VAL;
         loadClip = 1'b1;
      end
   end

   // clip is high only for the cycle after a saturating load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clip_q <= 1'b0;
      end else begin
         clip_q <= pop && loadClip;
      end
   end

   assign clip = clip_q;
`else
   // Plain shift; overflowing bits simply fall off the top.
   always_comb begin
      loadData = '0;
      case (SW)
         2'b01:   loadData = headData << 2;
         2'b11:   loadData = headData << 1;
         2'b10:   loadData = headData;
         default: loadData = '0;
      endcase
   end

   assign clip = 1'b0;
`endif

   // Occupancy moves only when exactly one of push/pop happens.
   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
   end

   // Sample storage carries no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= in_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         level_q <= level_d;
      end
   end

   // Output register: a pop loads the scaled head, otherwise an accepted
   // word empties the stage; a stalled word is left untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outValid_q <= 1'b0;
         outData_q  <= '0;
      end else if (pop) begin
         outValid_q <= 1'b1;
         outData_q  <= loadData;
      end else if (out_ready) begin
         outValid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_audio_gain_fifo.sv
// tb_audio_gain_fifo: scoreboard bench for audio_gain_fifo (32-bit, depth 4).
// Expected outputs come from an arithmetic gain model evaluated when a
// sample is accepted; SW is only changed while the pipeline is empty or
// after the affected sample has been loaded. Honours AUDIO_GAIN_SAT_EN.
module tb_audio_gain_fifo;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int LVL_W  = $clog2(DEPTH+1);

   typedef struct {
      logic [31:0] data;
      logic        clip;
   } expItem_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        SW;
   logic [LVL_W-1:0]  level;
   logic              clip;

   expItem_t    sbQueue[$];
   int          errCount   = 0;
   int          checkCount = 0;
   logic        prevStall  = 1'b0;
   logic [31:0] prevData   = '0;
   logic        fresh;
   expItem_t    head;
   bit          batchDone;

   audio_gain_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .SW        (SW),
      .level     (level),
      .clip      (clip)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Reference gain: multiply as a wide signed integer, then clamp or wrap.
   function automatic expItem_t refModel(input logic [31:0] s, input logic [1:0] sw);
      expItem_t r;
      longint   v;
      v = longint'($signed(s));
      case (sw)
         2'b00:   v = 0;
         2'b01:   v = v * 4;
         2'b11:   v = v * 2;
         default: v = v;
      endcase
      r.clip = 1'b0;
`ifdef AUDIO_GAIN_SAT_EN
      if (v > 64'sd2147483647) begin
         v = 64'sd2147483647;
         r.clip = 1'b1;
      end else if (v < -64'sd2147483648) begin
         v = -64'sd2147483648;
         r.clip = 1'b1;
      end
`endif
      r.data = v[31:0];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Offer one sample until it is taken; the expected result is queued the
   // moment acceptance is certain (in_valid and in_ready ahead of the edge).
   task automatic applyStimulus(input logic [31:0] data);
      bit taken = 0;
      in_data  = data;
      in_valid = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (in_ready) begin
            taken = 1;
            sbQueue.push_back(refModel(data, SW));
            break;
         end
      end
      checkCount++;
      if (!taken) begin
         errCount++;
         $display("[TB] FAIL accept_timeout: got not accepted expected accepted for 0x%08h", data);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Let everything flow out and wait until the block is fully empty.
   task automatic drain(input string name);
      bit done = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (sbQueue.size() == 0 && !out_valid && level == '0) begin
            done = 1;
            break;
         end
      end
      checkCount++;
      if (!done) begin
         errCount++;
         $display("[TB] FAIL %s_drain: got level=%0d queued=%0d expected empty", name, level, sbQueue.size());
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] randSample();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'($urandom_range(0, 255));
         2:       return 32'h3FFF_FF00 + 32'($urandom_range(0, 511));
         default: return 32'hC000_0100 - 32'($urandom_range(0, 511));
      endcase
   endfunction

   // Monitor: compare every presented word with the scoreboard head, check
   // stall stability, clip timing and the in_ready/level relationship.
   always @(negedge clk) begin
      if (reset) begin
         prevStall = 1'b0;
      end else begin
         fresh = !prevStall;
         if (prevStall) begin
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_data", out_data, prevData);
         end
         if (out_valid) begin
            if (sbQueue.size() == 0) begin
               checkCount++;
               errCount++;
               $display("[TB] FAIL unexpected_output: got 0x%08h expected no output", out_data);
            end else begin
               head = sbQueue[0];
               checkOutput("out_data", out_data, head.data);
               checkOutput("clip_load", 32'(clip), 32'(fresh ? head.clip : 1'b0));
               if (out_ready) begin
                  void'(sbQueue.pop_front());
               end
            end
         end else begin
            checkOutput("clip_idle", 32'(clip), 32'd0);
         end
         checkOutput("ready_vs_level", 32'(in_ready), 32'(level != LVL_W'(DEPTH)));
         checkOutput("level_bound", 32'(level <= LVL_W'(DEPTH)), 32'd1);
         prevStall = out_valid && !out_ready;
         prevData  = out_data;
      end
   end

   initial begin
      reset     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      SW        = 2'b10;
      #1 reset  = 1'b1;
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", out_data, 32'd0);
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_clip", 32'(clip), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;

      // x2 gain, one-cycle latency from accept to out_valid.
      SW        = 2'b11;
      out_ready = 1'b1;
      applyStimulus(32'h0000_1000);
      checkOutput("lat_level", 32'(level), 32'd1);
      checkOutput("lat_early_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("lat_valid", 32'(out_valid), 32'd1);
      checkOutput("lat_data", out_data, 32'h0000_2000);
      drain("x2");

      // x4 gain on large magnitudes: clamp or wrap depending on build.
      SW = 2'b01;
      applyStimulus(32'h4000_0000);
      @(posedge clk);
      #1;
`ifdef AUDIO_GAIN_SAT_EN
      checkOutput("sat_pos_data", out_data, 32'h7FFF_FFFF);
      checkOutput("sat_pos_clip", 32'(clip), 32'd1);
`else
      checkOutput("wrap_pos_data", out_data, 32'h0000_0000);
      checkOutput("wrap_pos_clip", 32'(clip), 32'd0);
`endif
      applyStimulus(32'hC000_0000);
      @(posedge clk);
      #1;
`ifdef AUDIO_GAIN_SAT_EN
      checkOutput("sat_neg_data", out_data, 32'h8000_0000);
      checkOutput("sat_neg_clip", 32'(clip), 32'd1);
`else
      checkOutput("wrap_neg_data", out_data, 32'h0000_0000);
      checkOutput("wrap_neg_clip", 32'(clip), 32'd0);
`endif
      drain("x4");

      // Fill against a stalled sink: one word held, four queued, full.
      SW        = 2'b10;
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(32'(i));
      end
      checkOutput("full_level", 32'(level), 32'd4);
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      checkOutput("full_out_data", out_data, 32'd1);
      checkOutput("full_out_valid", 32'(out_valid), 32'd1);
      drain("full");

      // Mute still consumes the sample.
      SW = 2'b00;
      applyStimulus(32'h0000_1234);
      @(posedge clk);
      #1;
      checkOutput("mute_valid", 32'(out_valid), 32'd1);
      checkOutput("mute_data", out_data, 32'd0);
      drain("mute");

      // A gain change during a stall must not touch the loaded word.
      out_ready = 1'b0;
      SW        = 2'b11;
      applyStimulus(32'h0000_1000);
      @(posedge clk);
      #1;
      checkOutput("stall_loaded", out_data, 32'h0000_2000);
      SW = 2'b01;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("stall_after_sw", out_data, 32'h0000_2000);
      applyStimulus(32'h0000_1000);
      checkOutput("stall_still", out_data, 32'h0000_2000);
      drain("swchange");

      // Reset with a held word and three queued: all of it must vanish.
      SW        = 2'b10;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(32'hDEAD_0000 + 32'(i));
      end
      checkOutput("pre_rst_level", 32'(level), 32'd3);
      checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      sbQueue.delete();
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_level", 32'(level), 32'd0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midrst_data", out_data, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      applyStimulus(32'h0000_0077);
      applyStimulus(32'h0000_0088);
      drain("post_rst");

      // Randomised batches: SW fixed per batch, sink readiness random.
      for (int b = 0; b < 8; b++) begin
         SW        = 2'($urandom_range(0, 3));
         batchDone = 0;
         fork
            begin
               for (int n = 0; n < 20; n++) begin
                  applyStimulus(randSample());
                  repeat ($urandom_range(0, 2)) begin
                     @(posedge clk);
                     #1;
                  end
               end
               batchDone = 1;
            end
            begin
               while (!batchDone) begin
                  @(posedge clk);
                  #1;
                  out_ready = 1'($urandom_range(0, 1));
               end
            end
         join
         drain("random");
      end

      checkOutput("final_queue_empty", 32'(sbQueue.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
